// File: rtl/prbs_checker_if.sv
// Stream port of the PRBS checker: received words in, lock/error status and counters out.
// in_vld qualifies in_data for one cycle; there is no back-pressure, so every valid word is consumed.
interface prbs_checker_if #(
  parameter int CNT_W = 16
);
  logic             in_vld;
  logic [7:0]       in_data;
  logic             clr;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic [1:0]       dbg_state;

  modport master (
    output in_vld, in_data, clr,
    input  locked, err, err_cnt, word_cnt, dbg_state
  );

  modport slave (
    input  in_vld, in_data, clr,
    output locked, err, err_cnt, word_cnt, dbg_state
  );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the x^8+x^6+x^5+x^4+1 word stream: locks without the seed,
// then predicts every word and counts mismatches.
module prbs_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input logic           clk,
  input logic           rst_n,
  prbs_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q;
  logic [7:0]       ref_q;
  logic [3:0]       match_run;
  logic [3:0]       miss_run;
  logic             locked_q;
  logic             err_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] word_cnt_q;

  function automatic logic [7:0] next_word(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  logic       hit;
  logic       zero_in;
  logic [7:0] nxt_in;
  logic [7:0] nxt_ref;

  assign hit     = (bus.in_data == ref_q);
  assign zero_in = (bus.in_data == 8'h00);
  assign nxt_in  = next_word(bus.in_data);
  assign nxt_ref = next_word(ref_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ref_q      <= 8'h00;
      match_run  <= 4'd0;
      miss_run   <= 4'd0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      err_q <= 1'b0;
      if (bus.in_vld) begin
        case (state_q)
          IDLE: begin
            if (!zero_in) begin
              ref_q     <= nxt_in;
              match_run <= 4'd0;
              state_q   <= SEARCH;
            end
          end
          SEARCH: begin
            // A legal ref is never 0x00, so a hit implies a nonzero word.
            if (hit) begin
              ref_q <= nxt_in;
              if (match_run == 4'(LOCK_CNT - 1)) begin
                match_run <= 4'd0;
                miss_run  <= 4'd0;
                locked_q  <= 1'b1;
                state_q   <= LOCKED;
              end else begin
                match_run <= match_run + 4'd1;
              end
            end else begin
              match_run <= 4'd0;
              ref_q     <= nxt_in;
              if (zero_in) state_q <= IDLE;
            end
          end
          LOCKED: begin
            if (word_cnt_q != '1) word_cnt_q <= word_cnt_q + CNT_W'(1);
            if (hit) begin
              miss_run <= 4'd0;
              ref_q    <= nxt_ref;
            end else begin
              err_q <= 1'b1;
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
              if (miss_run == 4'(UNLOCK_CNT - 1)) begin
                // Too many misses in a row: assume a slip and resync on this word.
                miss_run  <= 4'd0;
                match_run <= 4'd0;
                locked_q  <= 1'b0;
                ref_q     <= nxt_in;
                state_q   <= zero_in ? IDLE : SEARCH;
              end else begin
                miss_run <= miss_run + 4'd1;
                ref_q    <= nxt_ref;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      if (bus.clr) begin
        err_cnt_q  <= '0;
        word_cnt_q <= '0;
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.word_cnt  = word_cnt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a 16-bit and a 4-bit counter instance driven with the same randomized
// word stream, checked against a sequence-position reference model through an expected queue.
module tb_prbs_checker;

  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 3;
  localparam int W          = 44;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prbs_checker_if #(.CNT_W(16)) b16 ();
  prbs_checker_if #(.CNT_W(4))  b4 ();

  prbs_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(b16)
  );
  prbs_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
  );

  logic [W-1:0] act_v;
  assign act_v = {b16.locked, b16.err, b16.err_cnt, b16.word_cnt,
                  b4.locked, b4.err, b4.err_cnt, b4.word_cnt};

  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  // Sequence table: the whole 255-word period and the position of every legal word.
  logic [7:0] seq [255];
  int         pos_of [256];
  int         g;

  localparam int M_IDLE = 0, M_SEARCH = 1, M_LOCKED = 2;
  int m_mode, m_pos, m_run, m_miss, m_errs, m_words;

  function automatic int succ(input int p);
    return (p + 1) % 255;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_run = 0; m_miss = 0; m_errs = 0; m_words = 0;
  endtask

  task automatic model_step(input bit vld, input logic [7:0] d, input bit c, output bit e);
    e = 1'b0;
    if (vld) begin
      case (m_mode)
        M_IDLE: if (d != 8'h00) begin
          m_mode = M_SEARCH; m_run = 0; m_pos = succ(pos_of[d]);
        end
        M_SEARCH: begin
          if (d == seq[m_pos]) begin
            m_run++; m_pos = succ(m_pos);
            if (m_run == LOCK_CNT) begin m_mode = M_LOCKED; m_miss = 0; end
          end else begin
            m_run = 0;
            if (d == 8'h00) m_mode = M_IDLE;
            else m_pos = succ(pos_of[d]);
          end
        end
        default: begin
          m_words++;
          if (d == seq[m_pos]) m_miss = 0;
          else begin e = 1'b1; m_errs++; m_miss++; end
          m_pos = succ(m_pos);
          if (m_miss == UNLOCK_CNT) begin
            m_run = 0; m_miss = 0;
            if (d == 8'h00) m_mode = M_IDLE;
            else begin m_mode = M_SEARCH; m_pos = succ(pos_of[d]); end
          end
        end
      endcase
    end
    if (c) begin m_errs = 0; m_words = 0; end
  endtask

  function automatic logic [W-1:0] model_out(input bit e);
    logic lk;
    lk = (m_mode == M_LOCKED);
    return {lk, e, 16'(sat(m_errs, 16)), 16'(sat(m_words, 16)),
            lk, e, 4'(sat(m_errs, 4)), 4'(sat(m_words, 4))};
  endfunction

  task automatic set_inputs(input bit vld, input logic [7:0] d, input bit c);
    b16.in_vld = vld; b16.in_data = d; b16.clr = c;
    b4.in_vld  = vld; b4.in_data  = d; b4.clr  = c;
  endtask

  task automatic drive(input bit vld, input logic [7:0] d, input bit c);
    bit e;
    set_inputs(vld, d, c);
    @(posedge clk); #1;
    model_step(vld, d, c, e);
    exp_q.push_back(model_out(e));
  endtask

  task automatic send_good(input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 8'($urandom), 1'b0);
    drive(1'b1, seq[g], 1'b0);
    g = succ(g);
  endtask

  task automatic send_word(input logic [7:0] d, input bit c);
    drive(1'b1, d, c);
    g = succ(g);
  endtask

  task automatic async_reset_check(input string name);
    @(negedge clk); #2;
    set_inputs(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    check(name, act_v, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check("cycle_out", act_v, exp_q.pop_front());
  end

  initial begin
    logic [7:0] s;
    logic [7:0] d;
    int kind;
    s = 8'h01;
    pos_of[0] = 0;
    for (int i = 0; i < 255; i++) begin
      seq[i] = s; pos_of[s] = i;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    model_reset();
    set_inputs(1'b0, 8'h00, 1'b0);
    #12;
    check("reset_state", act_v, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Lock from seed 0x88: locked the cycle after 0x86.
    g = pos_of[8'h88];
    repeat (4) send_good(1'b0);
    check("not_locked_before_0x86", W'(b16.locked), W'(0));
    send_good(1'b0);
    check("locked_after_0x86", W'(b16.locked), W'(1));
    repeat (20) send_good(1'b1);

    // Single corrupted word 0x1A -> 0x1B.
    while (seq[g] != 8'h1A) send_good(1'b0);
    send_word(8'h1B, 1'b0);
    check("err_on_0x1b", W'({b16.err, b16.locked}), W'(2'b11));
    repeat (10) send_good(1'b1);

    // Three consecutive corruptions drop lock, clean stream relocks.
    repeat (3) send_word(seq[g] ^ 8'h40, 1'b0);
    check("unlocked_after_3", W'(b16.locked), W'(0));
    repeat (12) send_good(1'b1);

    // 0x00 while locked is an error; clr during an error word.
    send_word(8'h00, 1'b0);
    repeat (3) send_good(1'b0);
    send_word(seq[g] ^ 8'h01, 1'b1);
    check("clr_err_word", W'({b16.err, b16.err_cnt}), W'({1'b1, 16'd0}));
    repeat (5) send_good(1'b1);

    // Lockup-value stream stays idle.
    async_reset_check("async_rst_1");
    repeat (10) drive(1'b1, 8'h00, 1'b0);

    // Relock, then corrupt every other word: 4-bit counter must saturate.
    g = $urandom_range(0, 254);
    repeat (6) send_good(1'b1);
    repeat (40) begin
      send_word(seq[g] ^ 8'(1 << $urandom_range(0, 7)), 1'b0);
      send_good(1'b0);
    end

    // Randomized mix of gaps, corruptions, zero words, slips and clears.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 8'($urandom), ($urandom_range(0, 31) == 0));
      end else begin
        kind = $urandom_range(0, 19);
        if (kind == 4) g = $urandom_range(0, 254);
        case (kind)
          0: d = 8'h00;
          1, 2: d = seq[g] ^ 8'(1 << $urandom_range(0, 7));
          3: d = 8'($urandom);
          default: d = seq[g];
        endcase
        send_word(d, ($urandom_range(0, 31) == 0));
      end
    end

    async_reset_check("async_rst_2");
    repeat (8) send_good(1'b1);

    repeat (4) @(negedge clk);
    #1;
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
Receive-side partner of the 8-bit LFSR generator. Consumes the generator's word stream, locks to it without needing the seed, predicts each following word, and flags and counts mismatches. Used on looped-back or link paths to measure bit/word error behaviour of the datapath between generator and checker.

Parameters:
LOCK_CNT, 4, consecutive correct predictions needed in SEARCH to declare lock (1..15)
UNLOCK_CNT, 3, consecutive mismatches in LOCKED that drop lock (1..15)
CNT_W, 16, width of err_cnt and word_cnt

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_vld  in  1  in_data holds a stream word this cycle
in_data  in  8  received LFSR word
clr  in  1  synchronous clear of err_cnt/word_cnt; lock state untouched
locked  out  1  checker locked to stream
err  out  1  one-cycle pulse: last accepted word mismatched while LOCKED
err_cnt  out  CNT_W  saturating count of LOCKED mismatches
word_cnt  out  CNT_W  saturating count of words checked while LOCKED

Behaviour:
- Polynomial, identical to the generator: next(s) = {s[6:0], s[7]^s[5]^s[4]^s[3]} (x^8+x^6+x^5+x^4+1, period 255). 0x00 is the lockup value and never a legal word.
- Reset: state IDLE, ref=0x00, match_run=0, miss_run=0, locked=0, err=0, err_cnt=0, word_cnt=0.
- Cycles with in_vld=0: no state, counter or ref change; err=0.
- IDLE: on in_vld with in_data!=0x00: ref<=next(in_data), go SEARCH, match_run=0. in_data==0x00: stay IDLE.
- SEARCH: on in_vld compare in_data to ref.
  - match and in_data!=0: match_run+1, ref<=next(in_data); when match_run reaches LOCK_CNT go LOCKED, locked=1 registered on the same edge.
  - mismatch: match_run=0, ref<=next(in_data) (resync); if in_data==0x00 go IDLE.
  - err never pulses and counters never change in SEARCH/IDLE.
- LOCKED: ref free-runs from its own value: ref<=next(ref) on every in_vld regardless of match (a single corrupted word costs exactly one error).
  - word_cnt+1 per accepted word.
  - mismatch (incl. 0x00): err=1 next cycle, err_cnt+1, miss_run+1; when miss_run reaches UNLOCK_CNT: locked=0, go SEARCH, match_run=0, ref<=next(in_data) (resync; 0x00 -> IDLE).
  - match: miss_run=0, err=0.
- Latency: err, locked and counter updates visible the cycle after the in_vld edge that caused them.
- Counters saturate at 2^CNT_W-1; no wrap.
- clr priority: clr wins over a same-cycle increment (counter reads 0 next cycle); err pulse still produced.
- Async reset mid-stream returns to IDLE immediately; re-lock needs 1+LOCK_CNT valid words.

Test Plan:
- Reset, then stream from seed 0x88 (88,10,21,43,86,0D,...) one word/cycle -> locked=1 the cycle after word 0x86 is accepted; err never asserts; word_cnt tracks words after lock.
- Locked, replace one word 0x1A with 0x1B, rest correct -> exactly one err pulse, err_cnt=1, locked stays 1, following words no error.
- Locked, corrupt 3 consecutive words -> err on each, err_cnt=3, locked=0 after third; clean stream resumes -> relock after 4 further correct predictions.
- Stream of 0x00 words (generator seeded 0x00) -> stays IDLE, locked=0, counters 0; also inject 0x00 while locked -> counted as error.
- Gaps: in_vld toggled 1/0/0/1 over a correct stream -> lock and zero errors identical to gap-free run; clr during an error word -> err_cnt reads 0 next cycle, err pulses.
- CNT_W=4, persistent single-word corruption every other word -> err_cnt saturates at 15, no wrap; async reset mid-stream -> all outputs 0 same cycle.
